prog_clk_divider: RTL and testbench

- Multi-channel, runtime-programmable clock divider. It is the parametrised successor to the fixed single-channel divider in the tt_um top level.
- Each channel produces a registered, glitch-free divided clock with near-50% duty and a one-cycle tick pulse at each period boundary.
- The divide ratio of each channel is written at runtime through a simple write port. A new ratio takes effect only at that channel's period boundary.
- Sits between the tt_um top level (ui_in/uio_in decode) and the uo_out pins.

---
 rtl/prog_clk_div_pkg.sv | 9 +
 rtl/clk_div_channel.sv | 54 +++++
 rtl/prog_clk_divider.sv | 41 ++++
 tb/tb_prog_clk_divider.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/prog_clk_div_pkg.sv
// prog_clk_div_pkg: shared constants, ratio type and ratio clamp for the programmable clock divider
package prog_clk_div_pkg;
    localparam int MIN_DIV = 2;
    localparam int DEF_CNT_W = 10;
    typedef logic [DEF_CNT_W-1:0] div_t;
    function automatic logic [31:0] clamp_div(input logic [31:0] value);
        return (value < 32'(MIN_DIV)) ? 32'(MIN_DIV) : value;
    endfunction
endpackage

// File: rtl/clk_div_channel.sv
// clk_div_channel: one divider channel with counter, active/shadow ratio and pending flag (sync input under PROG_CLK_DIV_SYNC_EN)
module clk_div_channel
    import prog_clk_div_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int DEFAULT_DIV = 1000
) (
    input  logic             clk,
    input  logic             reset,
`ifdef PROG_CLK_DIV_SYNC_EN
    input  logic             sync,
`endif
    input  logic             en,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_div,
    output logic             div_clk,
    output logic             tick,
    output logic             pending
);
    logic [CNT_W-1:0] cnt, active_div, shadow_div, new_div, apply_div, cnt_nx, div_nx;
    logic wrap, restart, apply;
    // next-state: a restart (disable or sync) or a wrap zeroes the count and loads the newest ratio
    always_comb begin
        new_div = CNT_W'(clamp_div(32'(ld_div)));
        apply_div = ld ? new_div : shadow_div;
        wrap = en && cnt == active_div - 1'b1;
`ifdef PROG_CLK_DIV_SYNC_EN
        restart = !en || sync;
`else
        restart = !en;
`endif
        apply = restart || wrap;
        cnt_nx = apply ? '0 : cnt + 1'b1;
        div_nx = apply ? apply_div : active_div;
    end
    // outputs are registered from the next count so they stay aligned with cnt and glitch-free
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            active_div <= CNT_W'(DEFAULT_DIV);
            shadow_div <= CNT_W'(DEFAULT_DIV);
            div_clk <= 1'b0;
            tick <= 1'b0;
            pending <= 1'b0;
        end else begin
            cnt <= cnt_nx;
            active_div <= div_nx;
            if (ld) shadow_div <= new_div;
            pending <= apply ? 1'b0 : (pending || ld);
            div_clk <= cnt_nx >= (div_nx >> 1);
            tick <= cnt_nx == div_nx - 1'b1;
        end
    end
endmodule

// File: rtl/prog_clk_divider.sv
// prog_clk_divider: multi-channel runtime-programmable clock divider; PROG_CLK_DIV_SYNC_EN adds sync_in phase alignment
module prog_clk_divider
    import prog_clk_div_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W = DEF_CNT_W,
    parameter int DEFAULT_DIV = 1000,
    localparam int WCH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
`ifdef PROG_CLK_DIV_SYNC_EN
    input  logic              sync_in,
`endif
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              wr_en,
    input  logic [WCH_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    output logic [NUM_CH-1:0] div_clk,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);
    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            clk_div_channel #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
                .clk(clk),
                .reset(reset),
`ifdef PROG_CLK_DIV_SYNC_EN
                .sync(sync_in),
`endif
                .en(ch_en[i]),
                .ld(wr_en && wr_ch == WCH_W'(i)),
                .ld_div(wr_div),
                .div_clk(div_clk[i]),
                .tick(tick[i]),
                .pending(pending[i])
            );
        end
    endgenerate
endmodule

// File: tb/tb_prog_clk_divider.sv
// tb_prog_clk_divider: randomized self-checking bench against a phase/period reference model
module tb_prog_clk_divider;
    logic clk = 0, reset = 0, wr_en = 0;
    logic [3:0] ch_en = 0, div_clk, tick, pending;
    logic [1:0] wr_ch = 0;
    logic [9:0] wr_div = 0;
    int total = 0, bad = 0;
    int mp[4], md[4], ms[4];
    bit mpend[4];

    prog_clk_divider dut (.clk(clk), .reset(reset), .ch_en(ch_en), .wr_en(wr_en), .wr_ch(wr_ch),
                          .wr_div(wr_div), .div_clk(div_clk), .tick(tick), .pending(pending));

    always #5 clk = ~clk;

    // model: each channel is "phase p within a period of D cycles", low for the first D/2 cycles
    function automatic logic [3:0] exp_clk();
        for (int i = 0; i < 4; i++) exp_clk[i] = mp[i] >= md[i] / 2;
    endfunction
    function automatic logic [3:0] exp_tick();
        for (int i = 0; i < 4; i++) exp_tick[i] = mp[i] == md[i] - 1;
    endfunction
    function automatic logic [3:0] exp_pend();
        for (int i = 0; i < 4; i++) exp_pend[i] = mpend[i];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mp[i] = 0; md[i] = 1000; ms[i] = 1000; mpend[i] = 0;
        end
    endtask

    task automatic model_step();
        int nd;
        bit ld;
        if (reset) begin
            model_reset();
            return;
        end
        nd = (wr_div < 2) ? 2 : int'(wr_div);
        for (int i = 0; i < 4; i++) begin
            ld = wr_en && wr_ch == 2'(i);
            if (ld) ms[i] = nd;
            if (!ch_en[i] || mp[i] == md[i] - 1) begin
                md[i] = ms[i]; mp[i] = 0; mpend[i] = 0;
            end else begin
                mp[i]++;
                if (ld) mpend[i] = 1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1;
        model_reset();
        #1;
        total++;
        if ({div_clk, tick, pending} !== 12'h000) begin
            bad++; $display("FAIL reset_state got=%h exp=000", {div_clk, tick, pending});
        end
        cycle(); cycle();
        reset = 0; ch_en = 4'hF;
        for (int k = 0; k < 2100; k++) begin
            cycle();
            total++;
            if ({div_clk, tick, pending} !== {exp_clk(), exp_tick(), exp_pend()}) begin
                bad++; $display("FAIL default_div cyc=%0d got=%h exp=%h", k, {div_clk, tick, pending}, {exp_clk(), exp_tick(), exp_pend()});
            end
        end
    endtask

    task automatic test_write_mid();
        wr_en = 1; wr_ch = 1; wr_div = 5;
        cycle();
        wr_en = 0;
        total++;
        if (pending[1] !== 1'b1) begin
            bad++; $display("FAIL write_pending got=%b exp=1", pending[1]);
        end
        for (int k = 0; k < 1100; k++) begin
            cycle();
            total++;
            if ({div_clk, tick, pending} !== {exp_clk(), exp_tick(), exp_pend()}) begin
                bad++; $display("FAIL write_mid cyc=%0d got=%h exp=%h", k, {div_clk, tick, pending}, {exp_clk(), exp_tick(), exp_pend()});
            end
        end
    endtask

    task automatic test_clamp();
        wr_en = 1; wr_ch = 0; wr_div = 0;
        cycle();
        wr_ch = 2; wr_div = 1;
        cycle();
        wr_ch = 3; wr_div = 1023;
        cycle();
        wr_en = 0;
        for (int k = 0; k < 2200; k++) begin
            cycle();
            total++;
            if ({div_clk, tick, pending} !== {exp_clk(), exp_tick(), exp_pend()}) begin
                bad++; $display("FAIL clamp cyc=%0d got=%h exp=%h", k, {div_clk, tick, pending}, {exp_clk(), exp_tick(), exp_pend()});
            end
        end
    endtask

    task automatic test_wrap_write();
        logic [3:0] t;
        int k;
        t = exp_tick();
        for (k = 0; k < 2000 && !t[2]; k++) begin
            cycle();
            t = exp_tick();
        end
        total++;
        if (!t[2]) begin
            bad++; $display("FAIL wrap_wait got=timeout exp=tick2");
        end
        wr_en = 1; wr_ch = 2; wr_div = 8;
        cycle();
        wr_en = 0;
        total++;
        if (pending[2] !== 1'b0 || div_clk[2] !== 1'b0) begin
            bad++; $display("FAIL wrap_bypass got=p%b c%b exp=p0 c0", pending[2], div_clk[2]);
        end
        for (int j = 0; j < 20; j++) begin
            if (j == 3) begin wr_en = 1; wr_div = 6; end
            if (j == 4) wr_div = 9;
            if (j == 5) wr_en = 0;
            cycle();
            total++;
            if ({div_clk, tick, pending} !== {exp_clk(), exp_tick(), exp_pend()}) begin
                bad++; $display("FAIL wrap_write cyc=%0d got=%h exp=%h", j, {div_clk, tick, pending}, {exp_clk(), exp_tick(), exp_pend()});
            end
        end
        for (int j = 0; j < 40; j++) begin
            cycle();
            total++;
            if ({div_clk, tick, pending} !== {exp_clk(), exp_tick(), exp_pend()}) begin
                bad++; $display("FAIL last_wins cyc=%0d got=%h exp=%h", j, {div_clk, tick, pending}, {exp_clk(), exp_tick(), exp_pend()});
            end
        end
    endtask

    task automatic test_disable();
        logic [3:0] c;
        wr_en = 1; wr_ch = 3; wr_div = 7;
        cycle();
        wr_en = 0;
        c = exp_clk();
        for (int k = 0; k < 1100 && !c[3]; k++) begin
            cycle();
            c = exp_clk();
        end
        total++;
        if (div_clk[3] !== 1'b1) begin
            bad++; $display("FAIL high_phase_wait got=%b exp=1", div_clk[3]);
        end
        ch_en[3] = 0;
        cycle();
        total++;
        if ({div_clk[3], tick[3], pending[3]} !== 3'b000) begin
            bad++; $display("FAIL disable got=%b exp=000", {div_clk[3], tick[3], pending[3]});
        end
        for (int k = 0; k < 40; k++) begin
            if (k == 10) ch_en[3] = 1;
            cycle();
            total++;
            if ({div_clk, tick, pending} !== {exp_clk(), exp_tick(), exp_pend()}) begin
                bad++; $display("FAIL reenable cyc=%0d got=%h exp=%h", k, {div_clk, tick, pending}, {exp_clk(), exp_tick(), exp_pend()});
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            wr_en = ($urandom_range(0, 3) == 0);
            wr_ch = 2'($urandom_range(0, 3));
            wr_div = 10'($urandom_range(0, 12));
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 63) == 0) ch_en[i] = ~ch_en[i];
            cycle();
            total++;
            if ({div_clk, tick, pending} !== {exp_clk(), exp_tick(), exp_pend()}) begin
                bad++; $display("FAIL random cyc=%0d got=%h exp=%h", k, {div_clk, tick, pending}, {exp_clk(), exp_tick(), exp_pend()});
            end
        end
        wr_en = 0;
    endtask

    task automatic test_reset_mid();
        ch_en = 4'hF;
        for (int k = 0; k < 5; k++) cycle();
        wr_en = 1; wr_ch = 0; wr_div = 9;
        cycle();
        wr_en = 0;
        cycle();
        reset = 1;
        model_reset();
        #1;
        total++;
        if ({div_clk, tick, pending} !== 12'h000) begin
            bad++; $display("FAIL reset_mid got=%h exp=000", {div_clk, tick, pending});
        end
        cycle();
        reset = 0;
        for (int k = 0; k < 1100; k++) begin
            cycle();
            total++;
            if ({div_clk, tick, pending} !== {exp_clk(), exp_tick(), exp_pend()}) begin
                bad++; $display("FAIL after_reset cyc=%0d got=%h exp=%h", k, {div_clk, tick, pending}, {exp_clk(), exp_tick(), exp_pend()});
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_mid();
        test_clamp();
        test_wrap_write();
        test_disable();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
